// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a small circular buffer of (pc, instr) pairs sitting
// between fetch and decode. Redirects empty it; an empty queue presents a NOP.
module if_id_queue #(
  parameter int              DEPTH = 2,
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_misaligned,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // in_ready comes from registered occupancy only, so out_ready never reaches it
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_pc         = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instr      = out_valid ? instr_mem[rd_ptr] : NOP;
  assign out_pc_plus4   = out_pc + XLEN'(4);
  assign out_misaligned = out_valid & (out_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Pointer wrap relies on DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue (DEPTH=2) plus a streaming run.
module tb_if_id_queue;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;
    logic [1:0]  e_count;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_plus4;
    logic        e_mis;
  } vec_t;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic        out_misaligned;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  if_id_queue #(.DEPTH(2), .XLEN(32), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .out_misaligned(out_misaligned), .count(count)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] ins,
                             logic ordy, logic [1:0] ec, logic eir, logic eov,
                             logic [31:0] epc, logic [31:0] eins, logic [31:0] ep4, logic em);
    vec_t t;
    t.rst = r; t.flush = f; t.in_valid = iv; t.in_pc = pc; t.in_instr = ins; t.out_ready = ordy;
    t.e_count = ec; t.e_in_ready = eir; t.e_out_valid = eov; t.e_pc = epc;
    t.e_instr = eins; t.e_plus4 = ep4; t.e_mis = em;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of the next one
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] ec, input logic eir,
                             input logic eov, input logic [31:0] epc, input logic [31:0] eins,
                             input logic [31:0] ep4, input logic em);
    cmp({tag, ".count"},     32'(count),          32'(ec));
    cmp({tag, ".in_ready"},  32'(in_ready),       32'(eir));
    cmp({tag, ".out_valid"}, 32'(out_valid),      32'(eov));
    cmp({tag, ".out_pc"},    out_pc,              epc);
    cmp({tag, ".out_instr"}, out_instr,           eins);
    cmp({tag, ".pc_plus4"},  out_pc_plus4,        ep4);
    cmp({tag, ".misalign"},  32'(out_misaligned), 32'(em));
  endtask

  initial begin
    // Reset and idle
    vecs.push_back(v(0,0,0,32'h0,32'h0,0, 2'd0,1,0,32'h0,NOP,32'h4,0));
    vecs.push_back(v(0,0,0,32'h0,32'h0,0, 2'd0,1,0,32'h0,NOP,32'h4,0));
    vecs.push_back(v(1,0,0,32'h0,32'h0,0, 2'd0,1,0,32'h0,NOP,32'h4,0));
    // Fill and stall
    vecs.push_back(v(1,0,1,32'h00,32'h00500093,0, 2'd1,1,1,32'h00,32'h00500093,32'h04,0));
    vecs.push_back(v(1,0,1,32'h04,32'h00A00113,0, 2'd2,0,1,32'h00,32'h00500093,32'h04,0));
    vecs.push_back(v(1,0,1,32'h08,32'h00100193,0, 2'd2,0,1,32'h00,32'h00500093,32'h04,0));
    // Drain order
    vecs.push_back(v(1,0,0,32'h0,32'h0,1, 2'd1,1,1,32'h04,32'h00A00113,32'h08,0));
    vecs.push_back(v(1,0,0,32'h0,32'h0,1, 2'd0,1,0,32'h00,NOP,32'h04,0));
    // Flush with simultaneous push and pop, then held flush
    vecs.push_back(v(1,0,1,32'h10,32'h11111111,0, 2'd1,1,1,32'h10,32'h11111111,32'h14,0));
    vecs.push_back(v(1,0,1,32'h14,32'h22222222,0, 2'd2,0,1,32'h10,32'h11111111,32'h14,0));
    vecs.push_back(v(1,1,1,32'h18,32'h33333333,1, 2'd0,1,0,32'h00,NOP,32'h04,0));
    vecs.push_back(v(1,1,1,32'h1C,32'h33333333,1, 2'd0,1,0,32'h00,NOP,32'h04,0));
    vecs.push_back(v(1,0,1,32'h100,32'h44444444,0, 2'd1,1,1,32'h100,32'h44444444,32'h104,0));
    // Edge pcs: wrap of pc+4 and misalignment
    vecs.push_back(v(1,0,1,32'hFFFFFFFC,32'h55555555,1, 2'd1,1,1,32'hFFFFFFFC,32'h55555555,32'h0,0));
    vecs.push_back(v(1,0,1,32'h6,32'h66666666,1, 2'd1,1,1,32'h6,32'h66666666,32'hA,1));
    vecs.push_back(v(1,0,1,32'h200,32'h77777777,0, 2'd2,0,1,32'h6,32'h66666666,32'hA,1));
    // Reset beats flush and handshakes while full
    vecs.push_back(v(0,1,1,32'h204,32'h88888888,1, 2'd0,1,0,32'h0,NOP,32'h4,0));
    // Full with pop: push rejected, then accepted the next cycle
    vecs.push_back(v(1,0,1,32'h300,32'hAAAA0001,0, 2'd1,1,1,32'h300,32'hAAAA0001,32'h304,0));
    vecs.push_back(v(1,0,1,32'h304,32'hAAAA0002,0, 2'd2,0,1,32'h300,32'hAAAA0001,32'h304,0));
    vecs.push_back(v(1,0,1,32'h308,32'hAAAA0003,1, 2'd1,1,1,32'h304,32'hAAAA0002,32'h308,0));
    vecs.push_back(v(1,0,1,32'h308,32'hAAAA0003,0, 2'd2,0,1,32'h304,32'hAAAA0002,32'h308,0));
    vecs.push_back(v(1,0,0,32'h0,32'h0,1, 2'd1,1,1,32'h308,32'hAAAA0003,32'h30C,0));
    vecs.push_back(v(1,0,0,32'h0,32'h0,1, 2'd0,1,0,32'h0,NOP,32'h4,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].in_valid,
                    vecs[i].in_pc, vecs[i].in_instr, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_in_ready,
                  vecs[i].e_out_valid, vecs[i].e_pc, vecs[i].e_instr,
                  vecs[i].e_plus4, vecs[i].e_mis);
    end

    // Streaming: one push and one pop per cycle keeps a single entry in flight
    applyStimulus(1, 0, 1, 32'h0, 32'h10000000, 1);
    checkOutput("stream0", 2'd1, 1, 1, 32'h0, 32'h10000000, 32'h4, 0);
    for (int i = 1; i < 20; i++) begin
      applyStimulus(1, 0, 1, 32'(4 * i), 32'h10000000 | 32'(i), 1);
      checkOutput($sformatf("stream%0d", i), 2'd1, 1, 1, 32'(4 * i),
                  32'h10000000 | 32'(i), 32'(4 * i + 4), 0);
    end
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 1);
    checkOutput("stream_end", 2'd0, 1, 0, 32'h0, NOP, 32'h4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue and IF/ID pipeline register, directly downstream of the fetch stage.
- Captures each (pc, instruction) pair returned from instruction memory, buffers up to DEPTH entries in order, and presents them to decode with a valid/ready handshake.
- Backpressures fetch when full.
- Discards all buffered instructions on a control-flow redirect (branch taken, jal, jalr).

Parameters:
DEPTH, 2, number of queue entries; power of two, >= 2
XLEN, 32, width of pc and instruction
NOP, 32'h00000013, value driven on out_instr when queue empty (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
flush  input  1  redirect from execute (branch_taken | jal | jalr); empties queue
in_valid  input  1  fetch presents a valid pc/instruction pair
in_pc  input  XLEN  pc of incoming instruction
in_instr  input  XLEN  incoming instruction word
in_ready  output  1  queue can accept a push this cycle
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  XLEN  pc of head entry
out_pc_plus4  output  XLEN  out_pc + 4, modulo 2^XLEN
out_instr  output  XLEN  head instruction, or NOP when empty
out_misaligned  output  1  out_valid & (out_pc[1:0] != 0)
count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries, each {pc, instr}; write pointer wr_ptr, read pointer rd_ptr, occupancy count; pointers wrap modulo DEPTH.
- Reset (rst=0 at posedge): count=0, wr_ptr=0, rd_ptr=0.
  - Outputs after reset: out_valid=0, in_ready=1, out_instr=NOP, out_pc=0, out_pc_plus4=4, out_misaligned=0.
  - Entry contents are don't-care.
  - Reset overrides flush and any handshake in the same cycle.
- in_ready = (count != DEPTH); depends on registered state only, with no combinational path from out_ready.
- out_valid = (count != 0); out_pc/out_instr read combinationally from entry[rd_ptr].
- When empty: out_instr = NOP, out_pc = 0.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- push only: write entry[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop in the same cycle: both pointers advance, count unchanged. This is legal at any count < DEPTH, including empty?
  - No. When empty, pop=0, so empty+push simply pushes.
- When full: in_ready=0, so no push even if pop occurs that cycle. Next cycle count=DEPTH-1 and in_ready=1.
- Latency: entry pushed at posedge N is visible on out_* after posedge N, i.e. one cycle; no bypass from in_* to out_*.
- Order: strict FIFO; instructions leave in push order.
- Flush (rst=1, flush=1 at posedge):
  - count=0, rd_ptr=wr_ptr=0.
  - Any push or pop in that cycle is discarded.
  - Next cycle out_valid=0, in_ready=1.
  - Flush with queue already empty has no effect beyond pointer reset.
- Flush held multiple cycles: queue stays empty; in_valid ignored throughout.
- out_pc_plus4 wraps: out_pc=32'hFFFFFFFC gives 32'h00000000.
- Misaligned pc is accepted and queued unchanged; only out_misaligned flags it, and exception handling belongs to decode.
- in_valid with in_ready=0: input is not captured; fetch must hold pc/instruction until accepted.
- Synthesizable, single clock domain, no latches.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, out_pc_plus4=4.
- Fill/stall (DEPTH=2): push pc=0x00/instr=0x00500093 and pc=0x04/instr=0x00A00113 with out_ready=0 -> count=2, in_ready=0.
  - A third push of pc=0x08 is not accepted; out_pc=0x00, out_instr=0x00500093.
- Drain order: from full, out_ready=1 for 2 cycles -> out_pc 0x00 then 0x04, out_pc_plus4 0x04 then 0x08, then out_valid=0, count=0.
- Streaming: in_valid=1 and out_ready=1 every cycle for 20 pcs 0x00..0x4C after the first push.
  - count stays 1; each instruction appears exactly once, in order, one cycle after push; pointers wrap correctly.
- Flush with simultaneous push/pop: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0.
  - The pushed pc never appears at the output; the next push of pc=0x100 appears as head one cycle later.
- Edge values: push pc=0xFFFFFFFC -> out_pc_plus4=0x00000000, out_misaligned=0. Push pc=0x00000006 -> out_misaligned=1.
  - Assert rst=0 while count=2 -> count=0 next cycle.
